// File: rtl/range_pkg.sv
// Shared types and default widths for the range stream generator.
package range_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_LENW  = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

endpackage

// File: rtl/ramp_step.sv
// Combinational triangle-ramp step: turns at hi and lo, never wraps.
module ramp_step
    import range_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_value,
    input  dir_t             i_dir,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_nextValue,
    output dir_t             o_nextDir
);

    // One extra bit so the bound tests cannot be fooled by overflow.
    logic [WIDTH:0] w_upSum;
    logic [WIDTH:0] w_downLimit;

    assign w_upSum     = {1'b0, i_value} + {1'b0, i_step};
    assign w_downLimit = {1'b0, i_lo} + {1'b0, i_step};

    always_comb begin
        o_nextValue = i_value;
        o_nextDir   = i_dir;
        if (i_dir == DIR_UP) begin
            if (w_upSum >= {1'b0, i_hi}) begin
                o_nextValue = i_hi;
                o_nextDir   = DIR_DOWN;
            end else begin
                o_nextValue = w_upSum[WIDTH-1:0];
            end
        end else begin
            if ({1'b0, i_value} <= w_downLimit) begin
                o_nextValue = i_lo;
                o_nextDir   = DIR_UP;
            end else begin
                o_nextValue = i_value - i_step;
            end
        end
    end

endmodule

// File: rtl/range_stream_gen.sv
// Emits one bounded triangle-ramp stream per accepted start, then reports
// the spread (max - min) of the words it produced.
module range_stream_gen
    import range_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic [LENW-1:0]  len,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_range,
    output logic             cfg_error
);

    state_t           r_state;
    logic [WIDTH-1:0] r_lo, r_hi, r_step;
    logic [LENW-1:0]  r_len, r_cnt;
    dir_t             r_dir;
    logic [WIDTH-1:0] r_min, r_max;
    logic [WIDTH-1:0] r_data, r_expRange;
    logic             r_go, r_finish, r_busy, r_done, r_cfgError;

    state_t           w_state;
    logic [WIDTH-1:0] w_lo, w_hi, w_step;
    logic [LENW-1:0]  w_len, w_cnt;
    dir_t             w_dir;
    logic [WIDTH-1:0] w_min, w_max;
    logic [WIDTH-1:0] w_data, w_expRange;
    logic             w_go, w_finish, w_busy, w_done, w_cfgError;

    logic [WIDTH-1:0] w_rampValue;
    dir_t             w_rampDir;
    logic [LENW-1:0]  w_lastIdx;
    logic             w_cfgBad;
    logic             w_isLast;

    ramp_step #(.WIDTH(WIDTH)) u_ramp (
        .i_value     (r_data),
        .i_dir       (r_dir),
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .i_step      (r_step),
        .o_nextValue (w_rampValue),
        .o_nextDir   (w_rampDir)
    );

    assign w_cfgBad  = (lo > hi) || (step == '0) || (len < LENW'(2));
    assign w_lastIdx = r_len - LENW'(1);
    assign w_isLast  = (r_cnt == w_lastIdx);

    // Outputs are computed one cycle early here and registered below.
    always_comb begin
        w_state    = r_state;
        w_lo       = r_lo;
        w_hi       = r_hi;
        w_step     = r_step;
        w_len      = r_len;
        w_cnt      = r_cnt;
        w_dir      = r_dir;
        w_min      = r_min;
        w_max      = r_max;
        w_data     = '0;
        w_go       = 1'b0;
        w_finish   = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_cfgError = 1'b0;
        w_expRange = r_expRange;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_cfgBad) begin
                        w_cfgError = 1'b1;
                    end else begin
                        w_state = RUN;
                        w_lo    = lo;
                        w_hi    = hi;
                        w_step  = step;
                        w_len   = len;
                        w_cnt   = '0;
                        w_dir   = DIR_UP;
                        w_min   = lo;
                        w_max   = lo;
                        w_data  = lo;
                        w_go    = 1'b1;
                        w_busy  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_isLast) begin
                    w_state    = DONE;
                    w_done     = 1'b1;
                    w_expRange = r_max - r_min;
                end else begin
                    w_cnt    = r_cnt + LENW'(1);
                    w_data   = w_rampValue;
                    w_dir    = w_rampDir;
                    w_busy   = 1'b1;
                    w_finish = (w_cnt == w_lastIdx);
                    if (w_rampValue < r_min) w_min = w_rampValue;
                    if (w_rampValue > r_max) w_max = w_rampValue;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lo       <= '0;
            r_hi       <= '0;
            r_step     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_min      <= '0;
            r_max      <= '0;
            r_data     <= '0;
            r_go       <= 1'b0;
            r_finish   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfgError <= 1'b0;
            r_expRange <= '0;
        end else begin
            r_state    <= w_state;
            r_lo       <= w_lo;
            r_hi       <= w_hi;
            r_step     <= w_step;
            r_len      <= w_len;
            r_cnt      <= w_cnt;
            r_dir      <= w_dir;
            r_min      <= w_min;
            r_max      <= w_max;
            r_data     <= w_data;
            r_go       <= w_go;
            r_finish   <= w_finish;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_cfgError <= w_cfgError;
            r_expRange <= w_expRange;
        end
    end

    assign data_out  = r_data;
    assign go        = r_go;
    assign finish    = r_finish;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_error = r_cfgError;
    assign exp_range = r_expRange;

endmodule

// File: tb/tb_range_stream_gen.sv
// Self-checking bench for range_stream_gen: directed table, corner
// sequences and randomized configurations against a behavioural model.
module tb_range_stream_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] lo, hi, step;
    logic [7:0] len;
    logic [9:0] data_out;
    logic       go, finish, busy, done, cfg_error;
    logic [9:0] exp_range;

    int errCount   = 0;
    int checkCount = 0;

    logic [9:0] expWords [256];
    int         expRange;
    bit         expCfg;
    int         lastRange = 0;

    typedef struct packed {
        logic [9:0]       lo;
        logic [9:0]       hi;
        logic [9:0]       step;
        logic [7:0]       len;
        logic             cfgErr;
        logic [9:0]       expRange;
        logic [7:0][9:0]  words;
    } vec_t;

    vec_t vecs [6];

    range_stream_gen #(.WIDTH(10), .LENW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .step      (step),
        .len       (len),
        .data_out  (data_out),
        .go        (go),
        .finish    (finish),
        .busy      (busy),
        .done      (done),
        .exp_range (exp_range),
        .cfg_error (cfg_error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the triangle with unbounded integers, then take the
    // spread of the resulting list.
    task automatic modelStream(input int l, input int h, input int s, input int n);
        int v, mn, mx;
        bit up;
        expCfg = (l > h) || (s == 0) || (n < 2);
        expRange = 0;
        if (!expCfg) begin
            v = l;
            up = 1'b1;
            for (int k = 0; k < n; k++) begin
                expWords[k] = 10'(v);
                if (up) begin
                    if (v + s >= h) begin v = h; up = 1'b0; end
                    else v = v + s;
                end else begin
                    if (v <= l + s) begin v = l; up = 1'b1; end
                    else v = v - s;
                end
            end
            mn = int'(expWords[0]);
            mx = mn;
            for (int k = 1; k < n; k++) begin
                if (int'(expWords[k]) < mn) mn = int'(expWords[k]);
                if (int'(expWords[k]) > mx) mx = int'(expWords[k]);
            end
            expRange = mx - mn;
        end
    endtask

    // Drives one start and checks every cycle of the response against
    // expWords/expRange/expCfg; inputs and start are scrambled mid-stream.
    task automatic applyStimulus(input logic [9:0] l, input logic [9:0] h,
                                 input logic [9:0] s, input logic [7:0] n,
                                 input string tag);
        int nn;
        nn = int'(n);
        @(negedge clock);
        lo = l; hi = h; step = s; len = n; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (expCfg) begin
            checkOutput({tag, " cfg_error pulse"}, int'(cfg_error), 1);
            checkOutput({tag, " no go"}, int'(go), 0);
            checkOutput({tag, " not busy"}, int'(busy), 0);
            checkOutput({tag, " exp_range held"}, int'(exp_range), lastRange);
            @(negedge clock);
            checkOutput({tag, " cfg_error drops"}, int'(cfg_error), 0);
            checkOutput({tag, " still idle"}, int'(busy), 0);
        end else begin
            for (int k = 0; k < nn; k++) begin
                if (k > 0) @(negedge clock);
                checkOutput($sformatf("%s word%0d", tag, k), int'(data_out), int'(expWords[k]));
                checkOutput($sformatf("%s go%0d", tag, k), int'(go), int'(k == 0));
                checkOutput($sformatf("%s finish%0d", tag, k), int'(finish), int'(k == nn - 1));
                checkOutput($sformatf("%s busy%0d", tag, k), int'(busy), 1);
                lo = 10'($urandom); hi = 10'($urandom);
                step = 10'($urandom); len = 8'($urandom);
                start = 1'($urandom);
            end
            @(negedge clock);
            checkOutput({tag, " done"}, int'(done), 1);
            checkOutput({tag, " done busy"}, int'(busy), 0);
            checkOutput({tag, " done data"}, int'(data_out), 0);
            checkOutput({tag, " done finish"}, int'(finish), 0);
            checkOutput({tag, " exp_range"}, int'(exp_range), expRange);
            lastRange = expRange;
            start = 1'($urandom);
            @(negedge clock);
            start = 1'b0;
            checkOutput({tag, " done drops"}, int'(done), 0);
            checkOutput({tag, " idle busy"}, int'(busy), 0);
            checkOutput({tag, " exp_range hold"}, int'(exp_range), lastRange);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " data_out"}, int'(data_out), 0);
        checkOutput({tag, " go"}, int'(go), 0);
        checkOutput({tag, " finish"}, int'(finish), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " cfg_error"}, int'(cfg_error), 0);
        checkOutput({tag, " exp_range"}, int'(exp_range), 0);
    endtask

    initial begin
        logic [9:0] rl, rh, rs;
        logic [7:0] rn;
        logic [9:0] heldWords [3];
        int idx;

        vecs[0].lo = 10; vecs[0].hi = 20; vecs[0].step = 4; vecs[0].len = 6;
        vecs[0].cfgErr = 1'b0; vecs[0].expRange = 10;
        vecs[0].words = {10'd0, 10'd0, 10'd12, 10'd16, 10'd20, 10'd18, 10'd14, 10'd10};
        vecs[1].lo = 0; vecs[1].hi = 1023; vecs[1].step = 1000; vecs[1].len = 4;
        vecs[1].cfgErr = 1'b0; vecs[1].expRange = 1023;
        vecs[1].words = {10'd0, 10'd0, 10'd0, 10'd0, 10'd23, 10'd1023, 10'd1000, 10'd0};
        vecs[2].lo = 5; vecs[2].hi = 5; vecs[2].step = 1; vecs[2].len = 2;
        vecs[2].cfgErr = 1'b0; vecs[2].expRange = 0;
        vecs[2].words = {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd5, 10'd5};
        vecs[3].lo = 30; vecs[3].hi = 10; vecs[3].step = 1; vecs[3].len = 4;
        vecs[3].cfgErr = 1'b1; vecs[3].expRange = 0; vecs[3].words = '0;
        vecs[4].lo = 1; vecs[4].hi = 9; vecs[4].step = 2; vecs[4].len = 1;
        vecs[4].cfgErr = 1'b1; vecs[4].expRange = 0; vecs[4].words = '0;
        vecs[5].lo = 1; vecs[5].hi = 9; vecs[5].step = 0; vecs[5].len = 4;
        vecs[5].cfgErr = 1'b1; vecs[5].expRange = 0; vecs[5].words = '0;

        reset = 1'b1; start = 1'b0;
        lo = '0; hi = '0; step = '0; len = '0;
        #1;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Directed table with hand-derived expectations.
        for (int i = 0; i < 6; i++) begin
            expCfg = vecs[i].cfgErr;
            expRange = int'(vecs[i].expRange);
            for (int k = 0; k < 8; k++) expWords[k] = vecs[i].words[k];
            applyStimulus(vecs[i].lo, vecs[i].hi, vecs[i].step, vecs[i].len,
                          $sformatf("vec%0d", i));
        end

        // Reset while word 3 is on the output aborts the stream at once.
        modelStream(10, 20, 4, 6);
        @(negedge clock);
        lo = 10; hi = 20; step = 4; len = 6; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start = 1'b0;
            checkOutput($sformatf("pre-reset word%0d", k), int'(data_out), int'(expWords[k]));
        end
        #2 reset = 1'b1;
        #1 checkAllZero("async reset");
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput($sformatf("post-reset finish%0d", c), int'(finish), 0);
            checkOutput($sformatf("post-reset done%0d", c), int'(done), 0);
            checkOutput($sformatf("post-reset busy%0d", c), int'(busy), 0);
        end
        lastRange = 0;
        applyStimulus(10, 20, 4, 6, "after-reset");

        // start held for ten cycles: one stream, DONE, one idle cycle, then
        // a second stream.
        heldWords[0] = 1; heldWords[1] = 3; heldWords[2] = 5;
        @(negedge clock);
        lo = 1; hi = 9; step = 2; len = 3; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            idx = (c >= 6) ? c - 6 : c - 1;
            if ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) begin
                checkOutput($sformatf("held c%0d data", c), int'(data_out), int'(heldWords[idx]));
                checkOutput($sformatf("held c%0d busy", c), int'(busy), 1);
            end else begin
                checkOutput($sformatf("held c%0d data", c), int'(data_out), 0);
                checkOutput($sformatf("held c%0d busy", c), int'(busy), 0);
            end
            checkOutput($sformatf("held c%0d go", c), int'(go), int'(c == 1 || c == 6));
            checkOutput($sformatf("held c%0d finish", c), int'(finish), int'(c == 3 || c == 8));
            checkOutput($sformatf("held c%0d done", c), int'(done), int'(c == 4 || c == 9));
            if (c == 10) start = 1'b0;
        end
        lastRange = 4;

        // Randomized configurations against the behavioural model.
        for (int t = 0; t < 40; t++) begin
            rl = 10'($urandom);
            rh = 10'($urandom);
            if ($urandom_range(0, 3) != 0 && rl > rh) begin
                rs = rl; rl = rh; rh = rs;
            end
            rs = 10'($urandom_range(0, 300));
            rn = 8'($urandom_range(0, 12));
            modelStream(int'(rl), int'(rh), int'(rs), int'(rn));
            applyStimulus(rl, rh, rs, rn, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/range_stream_gen.md
RANGE_STREAM_GEN -- requirements
Module: range_stream_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the data word width.
REQ-002 SHALL have parameter LENW, default 8, giving the width of the stream-length field.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one stream; sampled only in IDLE.
REQ-006 lo  input  WIDTH  ramp lower bound (unsigned).
REQ-007 hi  input  WIDTH  ramp upper bound (unsigned).
REQ-008 step  input  WIDTH  ramp increment (unsigned).
REQ-009 len  input  LENW  number of words to emit.
REQ-010 data_out  output  WIDTH  current stream word.
REQ-011 go  output  1  high with the first word only.
REQ-012 finish  output  1  high with the last word only.
REQ-013 busy  output  1  high on every cycle a word is presented.
REQ-014 done  output  1  one-cycle pulse on the cycle after the finish cycle.
REQ-015 exp_range  output  WIDTH  max minus min of the words emitted; updated when done rises.
REQ-016 cfg_error  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-018 All outputs SHALL be registered.
REQ-019 IDLE: start=1 SHALL capture lo, hi, step and len.
REQ-020 Config check at start: a start with lo>hi, step==0 or len<2 SHALL assert cfg_error for the next cycle, stay in IDLE and emit no go.
REQ-021 A valid start SHALL move the FSM to RUN; word 0 appears the cycle after start.
REQ-022 RUN SHALL present word k, k=0..len-1, on consecutive cycles with busy=1.
REQ-023 go SHALL be 1 only when k=0, and finish SHALL be 1 only when k=len-1; go and finish are never high together.
REQ-024 Ramp: word 0 SHALL equal lo, with direction up.
REQ-025 Up step: if v+step >= hi, computed in WIDTH+1 bits, the next word SHALL be hi and direction flips to down; otherwise the next word is v+step.
REQ-026 Down step: if v <= lo+step, computed in WIDTH+1 bits, the next word SHALL be lo and direction flips to up; otherwise the next word is v-step.
REQ-027 When lo==hi, every word SHALL equal lo.
REQ-028 The block SHALL track the running min and max of the emitted words.
REQ-029 On the cycle after finish, the FSM SHALL enter DONE: done=1, exp_range=max-min, busy=0 and data_out=0; it returns to IDLE the following cycle.
REQ-030 exp_range SHALL hold its value until the next done.
REQ-031 start asserted while in RUN or DONE SHALL be ignored, with no queuing.
REQ-032 Input changes during RUN SHALL NOT affect the stream in progress, because the captured configuration is used.
REQ-033 Outside RUN: data_out, go and finish SHALL be 0.

Reset
REQ-034 reset SHALL force IDLE immediately, independent of clock.
REQ-035 While reset is high, data_out, go, finish, busy, done, cfg_error and exp_range SHALL all be 0.
REQ-036 Reset mid-stream SHALL abort the stream with no finish or done; the first start after reset release behaves normally.

Structure
REQ-037 Package range_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH and LENW defaults.
REQ-038 The ramp next-value logic (value, direction, lo, hi, step -> next value, next direction) SHALL be a combinational sub-module named ramp_step.
REQ-039 The WIDTH+1-bit compares SHALL live inside ramp_step.

Verification
REQ-040 Scenario: lo=10, hi=20, step=4, len=6 -> data_out is 10,14,18,20,16,12; go on the 10 cycle; finish on the 12 cycle; done next cycle; exp_range=10.
REQ-041 Scenario: lo=0, hi=1023, step=1000, len=4 -> data_out is 0,1000,1023,23 with no wrap; exp_range=1023.
REQ-042 Scenario: lo=5, hi=5, step=1, len=2 -> data_out is 5,5; go and finish on separate cycles; exp_range=0.
REQ-043 Scenario: lo=30, hi=10 -> one-cycle cfg_error and no go. Separately, len=1 -> cfg_error. Separately, step=0 -> cfg_error.
REQ-044 Scenario: lo=10, hi=20, step=4, len=6, reset asserted while word 3 is presented -> all outputs 0 at once, no finish or done; a new start after release gives a correct full stream.
REQ-045 Scenario: start held high for 10 cycles with len=3 -> exactly one stream, then a second stream starting the cycle after DONE returns to IDLE.
